// File: rtl/aes_sbox_pkg.sv
// AES S-box helpers shared by the dual-mode substitution pipeline.
// Holds the affine constant, the four 8x8 basis-change matrices and the
// composite-field GF(((2^2)^2)^2) arithmetic (normal bases at every level).
// Matrix layout: bits [8j+7:8j] hold the image of input bit j, so a basis
// change is the XOR of the rows selected by the set input bits.
package aes_sbox_pkg;

  localparam logic [7:0] AFFINE_C = 8'h63;

  // Polynomial (AES) basis -> composite normal basis, and back.
  localparam logic [63:0] A2X = {8'h98, 8'hF3, 8'hF2, 8'h48, 8'h09, 8'h81, 8'hA9, 8'hFF};
  localparam logic [63:0] X2A = {8'h64, 8'h78, 8'h6E, 8'h8C, 8'h68, 8'h29, 8'hDE, 8'h60};
  // Composite basis -> S-box output basis (affine matrix folded in), and the inverse.
  localparam logic [63:0] X2S = {8'h58, 8'h2D, 8'h9E, 8'h0B, 8'hDC, 8'h04, 8'h03, 8'h24};
  localparam logic [63:0] S2X = {8'h8C, 8'h79, 8'h05, 8'hEB, 8'h12, 8'h04, 8'h51, 8'h53};

  function automatic logic [7:0] change_basis(input logic [7:0] x, input logic [63:0] m);
    logic [7:0] y;
    y = '0;
    for (int j = 0; j < 8; j++) begin
      if (x[j]) y = y ^ m[8*j +: 8];
    end
    return y;
  endfunction

  // GF(2^2), normal basis (W^2, W).
  function automatic logic [1:0] g4_mul(input logic [1:0] x, input logic [1:0] y);
    logic e;
    e = (x[1] ^ x[0]) & (y[1] ^ y[0]);
    return {(x[1] & y[1]) ^ e, (x[0] & y[0]) ^ e};
  endfunction

  // Squaring is inversion in GF(2^2): a swap in a normal basis.
  function automatic logic [1:0] g4_sq(input logic [1:0] x);
    return {x[0], x[1]};
  endfunction

  function automatic logic [1:0] g4_scl_n(input logic [1:0] x);
    return {x[0], x[1] ^ x[0]};
  endfunction

  function automatic logic [1:0] g4_scl_n2(input logic [1:0] x);
    return {x[1] ^ x[0], x[1]};
  endfunction

  // GF(2^4), normal basis (Z^4, Z) over GF(2^2).
  function automatic logic [3:0] g16_mul(input logic [3:0] x, input logic [3:0] y);
    logic [1:0] e;
    e = g4_scl_n(g4_mul(x[3:2] ^ x[1:0], y[3:2] ^ y[1:0]));
    return {g4_mul(x[3:2], y[3:2]) ^ e, g4_mul(x[1:0], y[1:0]) ^ e};
  endfunction

  function automatic logic [3:0] g16_sq_scl(input logic [3:0] x);
    return {g4_sq(x[3:2] ^ x[1:0]), g4_scl_n2(g4_sq(x[1:0]))};
  endfunction

  function automatic logic [3:0] g16_inv(input logic [3:0] x);
    logic [1:0] c, d, e;
    c = g4_scl_n(g4_sq(x[3:2] ^ x[1:0]));
    d = g4_mul(x[3:2], x[1:0]);
    e = g4_sq(c ^ d);
    return {g4_mul(e, x[1:0]), g4_mul(e, x[3:2])};
  endfunction

  // First half of GF(2^8) inversion: returns {hi, lo, inverse of the GF(2^4) norm}.
  function automatic logic [11:0] inv_front(input logic [7:0] x);
    logic [3:0] e;
    e = g16_inv(g16_sq_scl(x[7:4] ^ x[3:0]) ^ g16_mul(x[7:4], x[3:0]));
    return {x[7:4], x[3:0], e};
  endfunction

  // Second half: the two GF(2^4) products that finish the inversion.
  function automatic logic [7:0] inv_back(input logic [11:0] f);
    return {g16_mul(f[3:0], f[7:4]), g16_mul(f[3:0], f[11:8])};
  endfunction

  // Inverse mode strips the affine constant before entering the field.
  function automatic logic [7:0] to_composite(input logic [7:0] x, input logic inverse);
    return inverse ? change_basis(x ^ AFFINE_C, S2X) : change_basis(x, A2X);
  endfunction

  // Forward mode adds the affine constant after leaving the field.
  function automatic logic [7:0] from_composite(input logic [7:0] y, input logic inverse);
    return inverse ? change_basis(y, X2A) : (change_basis(y, X2S) ^ AFFINE_C);
  endfunction

  // Per-lane width of the register after stage s; only the cut after the
  // GF(2^4) inversion (3-stage build) carries the wider {hi, lo, e} triple.
  function automatic int stage_out_w(input int ps, input int s);
    return (ps == 3 && s == 1) ? 12 : 8;
  endfunction

  function automatic int stage_in_w(input int ps, input int s);
    return (s == 0) ? 8 : stage_out_w(ps, s - 1);
  endfunction

endpackage

// File: rtl/aes_sbox_dual_lane_stage.sv
// One lane's combinational slice between two register cut points.
// Ports:
//   din     - lane value from the previous cut (the raw byte for stage 0)
//   inverse - mode flag of the beat travelling through this slice
//   dout    - lane value for the next cut (the substituted byte for the last stage)
module aes_sbox_dual_lane_stage
  import aes_sbox_pkg::*;
#(
  parameter int PIPE_STAGES = 2,
  parameter int STAGE       = 0
) (
  input  logic [stage_in_w(PIPE_STAGES, STAGE)-1:0]  din,
  input  logic                                       inverse,
  output logic [stage_out_w(PIPE_STAGES, STAGE)-1:0] dout
);

  if (PIPE_STAGES == 1) begin : g_full
    assign dout = from_composite(inv_back(inv_front(to_composite(din, inverse))), inverse);
  end else if (STAGE == 0) begin : g_in
    assign dout = to_composite(din, inverse);
  end else if (PIPE_STAGES == 2) begin : g_inv_out
    assign dout = from_composite(inv_back(inv_front(din)), inverse);
  end else if (STAGE == 1) begin : g_inv_front
    assign dout = inv_front(din);
  end else begin : g_inv_back
    assign dout = from_composite(inv_back(din), inverse);
  end

endmodule

// File: rtl/aes_sbox_dual_pipe.sv
// Multi-lane AES forward/inverse S-box with an elastic register pipeline.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_valid/in_ready     - input handshake, in_data lane k = bits [8k+7:8k]
//   in_inverse            - 0 forward S-box, 1 inverse S-box, for the whole beat
//   out_valid/out_ready   - output handshake, out_data lane-aligned with in_data
//   out_inverse           - mode flag of the beat on out_data
//   busy                  - any stage holds a beat
//
// Handshake: a beat moves across a boundary only in a cycle where valid and
// ready are both high there; valid never waits on ready, and a held beat keeps
// its data and flag unchanged until taken. A stage is ready when it is empty or
// its own beat leaves this cycle, so ready ripples combinationally from
// out_ready back to in_ready and bubbles collapse.
module aes_sbox_dual_pipe
  import aes_sbox_pkg::*;
#(
  parameter int N_LANES     = 4,
  parameter int PIPE_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*N_LANES-1:0] in_data,
  input  logic                 in_inverse,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*N_LANES-1:0] out_data,
  output logic                 out_inverse,
  output logic                 busy
);

  // Shared control for all lanes: stage valid and mode flag.
  logic [PIPE_STAGES-1:0] vld;
  logic [PIPE_STAGES-1:0] flag;
  logic [PIPE_STAGES-1:0] ready;
  logic [PIPE_STAGES-1:0] up_v;  // valid offered to stage s
  logic [PIPE_STAGES-1:0] up_f;  // flag offered to stage s

  always_comb begin
    logic down;
    ready = '0;
    up_v  = '0;
    up_f  = '0;
    down  = out_ready;
    for (int s = PIPE_STAGES - 1; s >= 0; s--) begin
      ready[s] = !vld[s] || down;
      down     = ready[s];
    end
    for (int s = 0; s < PIPE_STAGES; s++) begin
      up_v[s] = (s == 0) ? in_valid   : vld[(s == 0) ? 0 : s - 1];
      up_f[s] = (s == 0) ? in_inverse : flag[(s == 0) ? 0 : s - 1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= '0;
      flag <= '0;
    end else begin
      for (int s = 0; s < PIPE_STAGES; s++) begin
        if (ready[s]) begin
          vld[s] <= up_v[s];
          if (up_v[s]) flag[s] <= up_f[s];
        end
      end
    end
  end

  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
    localparam int IW = stage_in_w(PIPE_STAGES, s);
    localparam int OW = stage_out_w(PIPE_STAGES, s);

    logic [N_LANES*IW-1:0] din;
    logic [N_LANES*OW-1:0] comb_out;
    logic [N_LANES*OW-1:0] q;

    if (s == 0) begin : g_src_in
      assign din = in_data;
    end else begin : g_src_prev
      assign din = g_stage[s-1].q;
    end

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
      aes_sbox_dual_lane_stage #(
        .PIPE_STAGES (PIPE_STAGES),
        .STAGE       (s)
      ) u_lane (
        .din     (din[k*IW +: IW]),
        .inverse (up_f[s]),
        .dout    (comb_out[k*OW +: OW])
      );
    end

    // Data only loads with a real beat, so idle input data never disturbs state.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q <= '0;
      else if (ready[s] && up_v[s]) q <= comb_out;
    end
  end

  assign in_ready    = ready[0];
  assign out_valid   = vld[PIPE_STAGES-1];
  assign out_inverse = flag[PIPE_STAGES-1];
  assign out_data    = g_stage[PIPE_STAGES-1].q;
  assign busy        = |vld;

endmodule

// File: doc/aes_sbox_dual_pipe.md
AES_SBOX_DUAL_PIPE -- requirements
Module: aes_sbox_dual_pipe

Interface
REQ-001 SHALL have parameter N_LANES, default 4, number of independent byte lanes; legal range 1..16.
REQ-002 SHALL have parameter PIPE_STAGES, default 2, number of register stages; legal values 1, 2, 3.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  input beat present.
REQ-006 in_ready  output  1  block accepts beat this cycle.
REQ-007 in_data  input  8*N_LANES  lane k = bits [8k+7:8k].
REQ-008 in_inverse  input  1  0 = forward S-box, 1 = inverse S-box; applies to the whole beat.
REQ-009 out_valid  output  1  output beat present.
REQ-010 out_ready  input  1  downstream accepts beat.
REQ-011 out_data  output  8*N_LANES  substituted bytes, lane-aligned with in_data.
REQ-012 out_inverse  output  1  echo of the in_inverse of the beat on out_data.
REQ-013 busy  output  1  high when any stage holds a valid beat.

Function
REQ-014 Each lane SHALL compute the AES S-box (forward) or its inverse per the beat's in_inverse, using composite-field GF(((2^2)^2)^2) inversion with normal bases; affine constant 0x63 is applied on the input side in inverse mode and on the output side in forward mode.
REQ-015 Register cut points: PIPE_STAGES=1 -> output register only; 2 -> after input basis conversion/mode mux, plus output; 3 -> additionally after the GF(2^4) inversion inside GF(2^8) inversion.
REQ-016 Latency from accepted input to out_valid SHALL be exactly PIPE_STAGES cycles when out_ready is held high.
REQ-017 Throughput SHALL be one beat per cycle with out_ready high.
REQ-018 Each stage carries valid, inverse flag and data; a stage loads when it is empty or its contents advance in the same cycle (elastic, bubble-collapsing).
REQ-019 in_ready = stage-1 empty OR stage-1 advances this cycle; combinational path out_ready -> in_ready is allowed.
REQ-020 Transfer occurs only on valid && ready at each boundary; no beat dropped, duplicated or reordered.
REQ-021 While out_valid && !out_ready, out_data and out_inverse SHALL stay stable.
REQ-022 With out_ready low, block SHALL accept exactly PIPE_STAGES beats, then deassert in_ready.
REQ-023 Simultaneous accept and emit on a full pipeline SHALL sustain full throughput.
REQ-024 Beats of differing in_inverse SHALL be freely interleaved; mode never leaks between beats.
REQ-025 Input data with in_valid low SHALL not affect any state.
REQ-026 busy = OR of all stage valid bits.

Reset
REQ-027 On rst_n low, all stage valid bits, out_valid, busy SHALL clear immediately (async); data and flag registers clear to 0.
REQ-028 After reset, in_ready SHALL be 1 and out_data 0.
REQ-029 Reset mid-operation SHALL discard all in-flight beats; none emerge after release.
REQ-030 Reset deassertion takes effect at the first clk edge after rst_n rises; no other sequencing needed.

Structure
REQ-031 Package aes_sbox_pkg SHALL hold the four 8x8 basis-change matrices (A2X, X2S, S2X, X2A) as constants and AFFINE_C = 8'h63.
REQ-032 One sub-module aes_sbox_dual_lane_stage: one lane's combinational slice between cut points, selected by a stage-index parameter; instantiated N_LANES x PIPE_STAGES.
REQ-033 Handshake and valid/flag registers SHALL be shared across lanes, not per lane.

Verification
REQ-034 Forward, PIPE_STAGES=2: bytes 0x00, 0x01, 0x53 -> 0x63, 0x7C, 0xED two cycles later.
REQ-035 Inverse: 0x63, 0x7C, 0xED -> 0x00, 0x01, 0x53; all 256 values in both modes for every PIPE_STAGES, checked against a table model.
REQ-036 PIPE_STAGES=3, out_ready low 6 cycles, in_valid high: exactly 3 beats accepted, in_ready low from 4th cycle, outputs stable, order preserved on release.
REQ-037 N_LANES=4, alternating in_inverse each cycle, random out_ready (50%): scoreboard matches, out_inverse echoes correctly.
REQ-038 rst_n pulsed low with 2 beats in flight: out_valid and busy drop at once; no beats emerge afterward; in_ready=1 after release.
